// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_pkg
// Desc   : Shared types and constants for the MEM stage of the MIPS pipeline.
// Rev    : 1.0
// ============================================================================
package pipe_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } mem_state_t;

    localparam int          DEFAULT_DEPTH = 64;
    localparam int          WORD_BYTES    = 4;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  reg_dst;
    } wb_bundle_t;

    localparam wb_bundle_t WB_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module : data_ram
// Desc   : DEPTH x 32 data memory, one synchronous write port, async read.
// Rev    : 1.0
// ============================================================================
module data_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_stage
// Desc   : MIPS MEM stage: data memory, lw/sw, MEM/WB register, zero-fill FSM.
// Rev    : 1.0
// ============================================================================
module mem_stage
    import pipe_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic        RegWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RegisterDstM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUResultW,
    output logic [4:0]  RegisterDstW,
    output logic [31:0] ResultW,
    output logic        mem_busy,
    output logic        misalign_err
);

    localparam int          OFS_W     = $clog2(WORD_BYTES);
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

    mem_state_t    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          err_q, err_d;
    wb_bundle_t    wb_q, wb_d;

    logic [AW-1:0] w_idx;
    logic          w_aligned;
    logic          w_misalign;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_waddr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_rdata;
    logic          w_unused_addr_hi;

    // Upper address bits are dropped on purpose: accesses wrap modulo DEPTH.
    assign w_idx            = ALUResultM[AW+OFS_W-1:OFS_W];
    assign w_unused_addr_hi = ^ALUResultM[31:AW+OFS_W];
    assign w_aligned        = (ALUResultM[OFS_W-1:0] == '0);
    assign w_misalign       = (MemReadM | MemWriteM) & ~w_aligned;

    data_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_ram (
        .clk     (clk),
        .we_i    (w_ram_we),
        .waddr_i (w_ram_waddr),
        .wdata_i (w_ram_wdata),
        .raddr_i (w_idx),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            err_q     <= 1'b0;
            wb_q      <= WB_BUBBLE;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            err_q     <= err_d;
            wb_q      <= wb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        err_d       = err_q;
        wb_d        = WB_BUBBLE;
        w_ram_we    = 1'b0;
        w_ram_waddr = w_idx;
        w_ram_wdata = WriteDataM;
        case (state_q)
            ST_CLEAR: begin
                // Fill owns the write port; incoming instructions become bubbles.
                w_ram_we    = 1'b1;
                w_ram_waddr = clr_cnt_q;
                w_ram_wdata = ZERO_WORD;
                clr_cnt_d   = clr_cnt_q + AW'(1);
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ram_we           = MemWriteM & w_aligned;
                wb_d.reg_write     = RegWriteM & ~w_misalign;
                wb_d.mem_to_reg    = MemtoRegM;
                wb_d.read_data     = (MemReadM & w_aligned) ? w_ram_rdata : ZERO_WORD;
                wb_d.alu_result    = ALUResultM;
                wb_d.reg_dst       = RegisterDstM;
                if (w_misalign) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign RegWriteW    = wb_q.reg_write;
    assign MemtoRegW    = wb_q.mem_to_reg;
    assign ReadDataW    = wb_q.read_data;
    assign ALUResultW   = wb_q.alu_result;
    assign RegisterDstW = wb_q.reg_dst;
    assign ResultW      = wb_q.mem_to_reg ? wb_q.read_data : wb_q.alu_result;
    assign mem_busy     = (state_q == ST_CLEAR);
    assign misalign_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_stage
// Desc   : Directed vector bench for mem_stage (DEPTH = 64).
// Rev    : 1.0
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM, MemtoRegM, RegWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [4:0]  RegisterDstM;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ReadDataW, ALUResultW, ResultW;
    logic [4:0]  RegisterDstW;
    logic        mem_busy, misalign_err;

    int tests  = 0;
    int failed = 0;

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .MemtoRegM    (MemtoRegM),
        .RegWriteM    (RegWriteM),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .RegisterDstM (RegisterDstM),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .ReadDataW    (ReadDataW),
        .ALUResultW   (ALUResultW),
        .RegisterDstW (RegisterDstW),
        .ResultW      (ResultW),
        .mem_busy     (mem_busy),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, m2r, rw;
        logic [31:0] alu, wd;
        logic [4:0]  dst;
        logic        e_rw, e_m2r;
        logic [31:0] e_rdata, e_alu, e_res;
        logic [4:0]  e_dst;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst,
                       input logic e_rw, input logic [31:0] e_rdata, input logic e_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.m2r = m2r; v.rw = rw;
        v.alu = alu; v.wd = wd; v.dst = dst;
        v.e_rw = e_rw; v.e_m2r = m2r; v.e_rdata = e_rdata;
        v.e_alu = alu; v.e_dst = dst; v.e_err = e_err;
        v.e_res = m2r ? e_rdata : alu;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst);
        MemReadM = rd; MemWriteM = wr; MemtoRegM = m2r; RegWriteM = rw;
        ALUResultM = alu; WriteDataM = wd; RegisterDstM = dst;
    endtask

    task automatic check_w_zero(input string tag);
        chk({tag, ".RegWriteW"},    {31'd0, RegWriteW},    32'd0);
        chk({tag, ".MemtoRegW"},    {31'd0, MemtoRegW},    32'd0);
        chk({tag, ".ReadDataW"},    ReadDataW,             32'd0);
        chk({tag, ".ALUResultW"},   ALUResultW,            32'd0);
        chk({tag, ".RegisterDstW"}, {27'd0, RegisterDstW}, 32'd0);
        chk({tag, ".ResultW"},      ResultW,               32'd0);
        chk({tag, ".misalign_err"}, {31'd0, misalign_err}, 32'd0);
        chk({tag, ".mem_busy"},     {31'd0, mem_busy},     32'd1);
    endtask

    // Counts rising edges with mem_busy high; starts and ends on a negedge.
    task automatic count_fill(input string tag);
        int n = 0;
        while (mem_busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".busy_edges"}, n, 32'd64);
        chk({tag, ".bubble_rw"},  {31'd0, RegWriteW}, 32'd0);
        chk({tag, ".bubble_alu"}, ALUResultW, 32'd0);
        @(negedge clk);
    endtask

    task automatic step_check(input vec_t v, input int k);
        string t;
        drive(v.rd, v.wr, v.m2r, v.rw, v.alu, v.wd, v.dst);
        @(posedge clk); #1;
        t = $sformatf("vec%0d", k);
        chk({t, ".RegWriteW"},    {31'd0, RegWriteW},    {31'd0, v.e_rw});
        chk({t, ".MemtoRegW"},    {31'd0, MemtoRegW},    {31'd0, v.e_m2r});
        chk({t, ".ReadDataW"},    ReadDataW,             v.e_rdata);
        chk({t, ".ALUResultW"},   ALUResultW,            v.e_alu);
        chk({t, ".RegisterDstW"}, {27'd0, RegisterDstW}, {27'd0, v.e_dst});
        chk({t, ".ResultW"},      ResultW,               v.e_res);
        chk({t, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, v.e_err});
        chk({t, ".mem_busy"},     {31'd0, mem_busy},     32'd0);
        @(negedge clk);
    endtask

    initial begin
        // rd wr m2r rw  addr          wdata          dst    exp_rw exp_rdata      exp_err
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_00FC, 32'h0,         5'd3,  1'b1, 32'h0,         1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0,         5'd4,  1'b1, 32'h0,         1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hDEADBEEF,  5'd0,  1'b0, 32'h0,         1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0,         5'd8,  1'b1, 32'hDEADBEEF,  1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h12345678,  5'd0,  1'b0, 32'h0,         1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0,         5'd9,  1'b1, 32'h12345678,  1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0022, 32'hAAAAAAAA,  5'd0,  1'b0, 32'h0,         1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0,         5'd5,  1'b1, 32'h0,         1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0021, 32'h0,         5'd6,  1'b0, 32'h0,         1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0055, 32'h0,         5'd7,  1'b1, 32'h0,         1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h11112222,  5'd10, 1'b1, 32'hDEADBEEF,  1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0,         5'd11, 1'b1, 32'h11112222,  1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'hABCD_0000, 32'h0,         5'd31, 1'b0, 32'h0,         1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'hCAFEF00D,  5'd0,  1'b0, 32'h0,         1'b1);

        reset = 1'b0;
        // Instruction held during reset/fill must be dropped.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFFFFFF, 5'd2);
        repeat (2) @(negedge clk);
        check_w_zero("reset");
        reset = 1'b1;
        count_fill("fill");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

        foreach (vecs[k]) step_check(vecs[k], k);

        // Asynchronous reset in RUN: outputs clear immediately, fill restarts.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        reset = 1'b0;
        #1;
        check_w_zero("midrun");
        @(negedge clk);
        reset = 1'b1;
        count_fill("refill");

        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'h0, 5'd12);
        @(posedge clk); #1;
        chk("refill.load30",  ReadDataW, 32'h0);
        chk("refill.result",  ResultW,   32'h0);
        chk("refill.dst",     {27'd0, RegisterDstW}, 32'd12);
        chk("refill.err",     {31'd0, misalign_err}, 32'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, fed directly by the EX/MEM register outputs. Holds the word-addressed data memory, executes `lw`/`sw`, and registers the results into the MEM/WB boundary. After every reset, a clear state machine zero-fills the memory and holds the pipeline busy until the fill completes.

## Interface
- `DEPTH`, 64: data memory size in 32-bit words; power of two, ≥ 4.
- `AW`, log2(DEPTH): word-index width; derived, never overridden.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `MemReadM` in 1: load request.
- `MemWriteM` in 1: store request.
- `MemtoRegM` in 1: write-back source select (1 = memory data).
- `RegWriteM` in 1: destination register write enable.
- `ALUResultM` in 32: byte address, or ALU result for non-memory ops.
- `WriteDataM` in 32: store data (rt value).
- `RegisterDstM` in 5: destination register number.
- `RegWriteW` out 1: registered write enable.
- `MemtoRegW` out 1: registered source select.
- `ReadDataW` out 32: registered load data.
- `ALUResultW` out 32: registered ALU result.
- `RegisterDstW` out 5: registered destination register.
- `ResultW` out 32: combinational: `MemtoRegW ? ReadDataW : ALUResultW`.
- `mem_busy` out 1: high while clearing; hazard unit stalls IF/ID/EX while high.
- `misalign_err` out 1: sticky; set by any misaligned access.

## Operation
- **FSM states:** CLEAR and RUN.
  - Reset asserted forces CLEAR and `clr_cnt`=0.
  - In CLEAR, each cycle writes `mem[clr_cnt]`=0 and increments `clr_cnt`.
  - When `clr_cnt`==DEPTH-1 is written, the next state is RUN.
- **CLEAR behaviour:**
  - `mem_busy`=1.
  - `MemReadM`/`MemWriteM` are ignored.
  - The W registers load a bubble: all fields 0.
- **Word index** = `ALUResultM[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- **Aligned access** means `ALUResultM[1:0]`==0.
- **Store (RUN, `MemWriteM`, aligned):** `mem[idx]` ← `WriteDataM` at the rising edge.
- **Load (RUN, `MemReadM`, aligned):** asynchronous array read of `mem[idx]`, captured into `ReadDataW` at the edge.
- **`MemReadM` and `MemWriteM` both 1:** the store commits, and `ReadDataW` receives the pre-store (old) word.
- **Load of the word stored by the immediately preceding instruction:** returns the new data, since the store committed one edge earlier.
- **Misaligned access (`MemReadM|MemWriteM` with non-zero low bits):**
  - Store is suppressed.
  - `ReadDataW`=0.
  - `RegWriteW` is forced 0 for that instruction.
  - `misalign_err` ← 1; it stays set until reset.
- **Non-memory ops:** `ReadDataW` ← 0; the other W fields pass through.

## Timing
- **Latency:** M inputs appear on W outputs one rising edge later.
- **Reset values:** every W output is 0, `ResultW`=0, `misalign_err`=0, and `mem_busy`=1 during and after reset until CLEAR ends.
- **After reset deasserts:** `mem_busy` stays high for exactly DEPTH rising edges. The first edge with `mem_busy`=0 is the first edge that accepts an access.
- **Reset mid-CLEAR or mid-RUN:** CLEAR restarts from index 0. Partially written memory is overwritten by the fill.
- **No handshake on inputs.** The upstream stage must hold or bubble its instructions while `mem_busy`=1. Instructions presented during CLEAR are dropped.

## Structure
- **Shared package `pipe_pkg`:**
  - FSM state enum (`ST_CLEAR`, `ST_RUN`).
  - Default DEPTH constant.
  - `WORD_BYTES`=4.
  - Zero-word constant.
  - Bubble constant for the W bundle.
- **Sub-module `data_ram`:**
  - DEPTH×32 array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port.
  - No reset of its own.
  - Writes are muxed between the clear path and the store path by the FSM.
- `mem_stage` contains the FSM, clear counter, alignment check, W registers and `ResultW` mux.

## Test plan
- **Reset fill:** release reset → `mem_busy` high for 64 edges, then low. A load from byte address 0xFC then returns 0x00000000.
- **Store/load:** `sw` 0xDEADBEEF to address 0x10, next cycle `lw` 0x10 with `RegisterDstM`=8 → `ReadDataW`=0xDEADBEEF, `RegisterDstW`=8, `RegWriteW`=1, `ResultW`=0xDEADBEEF.
- **Wrap:** `sw` 0x12345678 to address 0x104 (DEPTH=64), then `lw` 0x004 → 0x12345678.
- **Misaligned:** `sw` 0xAAAAAAAA to address 0x22, then `lw` 0x20 → store suppressed, `misalign_err`=1, load returns the prior value 0. A later misaligned `lw` 0x21 → `RegWriteW`=0, `ReadDataW`=0.
- **Non-memory op:** `ALUResultM`=0x55, `MemtoRegM`=0, `RegWriteM`=1 → `ResultW`=0x55 after one edge.
- **Reset mid-RUN:** store 0xCAFEF00D, pulse reset low for 1 cycle → all W outputs 0, `misalign_err`=0, `mem_busy` high for 64 edges, and the stored word reads back as 0.
